// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: one req/ack word transaction per M-stage load/store,
// with a pipeline stall, misalignment and timeout error reporting.
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluoutm,
    input  logic [31:0] writedatam,
    input  logic        memwritem,
    input  logic        memtoregm,
    output logic [31:0] readdatam,
    output logic        stallm,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,     state_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_cnt_q,   err_cnt_d;

    logic op;
    logic misaligned;
    logic err_cnt_inc;

    assign op         = memwritem | memtoregm;
    assign misaligned = (aluoutm[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_pulse_d = 1'b0;
        err_cnt_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op) begin
                    if (misaligned) begin
                        rdata_d     = '0;
                        err_pulse_d = 1'b1;
                        err_cnt_inc = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = memwritem;
                        bus_addr_d  = {aluoutm[31:2], 2'b00};
                        bus_wdata_d = writedatam;
                        cnt_d       = '0;
                        state_d     = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    rdata_d   = bus_we_q ? '0 : bus_rdata;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d   = 1'b0;
                    rdata_d     = '0;
                    err_pulse_d = 1'b1;
                    err_cnt_inc = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Saturate rather than wrap so a long error burst stays visible.
        err_cnt_d = (err_cnt_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign stallm    = ((state_q == S_IDLE) && op) || (state_q == S_BUSY);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign readdatam = rdata_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl: reads, writes with waits, timeout,
// misalignment, mid-transaction reset, counter saturation and back-to-back ops.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluoutm;
    logic [31:0] writedatam;
    logic        memwritem;
    logic        memtoregm;
    logic [31:0] readdatam;
    logic        stallm;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err_pulse;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    mem_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .aluoutm   (aluoutm),
        .writedatam(writedatam),
        .memwritem (memwritem),
        .memtoregm (memtoregm),
        .readdatam (readdatam),
        .stallm    (stallm),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        total++;
        if ({bus_req, bus_we, err_pulse, stallm} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got req/we/err/stall=%b expected 0000", {bus_req, bus_we, err_pulse, stallm});
        end
        total++;
        if ({bus_addr, bus_wdata, readdatam, err_count} !== 104'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h errcnt=%0d expected all 0",
                     bus_addr, bus_wdata, readdatam, err_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait_read();
        aluoutm = 32'h0000_0010;
        memtoregm = 1'b1;
        #1;
        total++;
        if ({stallm, bus_req} !== 2'b10) begin
            bad++;
            $display("FAIL zw_idle: got stall/req=%b expected 10", {stallm, bus_req});
        end
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        #1;
        total++;
        if ({stallm, bus_req, bus_we} !== 3'b110 || bus_addr !== 32'h0000_0010) begin
            bad++;
            $display("FAIL zw_busy: got stall/req/we=%b addr=%h expected 110 addr=00000010",
                     {stallm, bus_req, bus_we}, bus_addr);
        end
        tick();
        total++;
        if (stallm !== 1'b0 || bus_req !== 1'b0 || readdatam !== 32'hCAFE_F00D || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL zw_done: got stall=%b req=%b rdata=%h err=%b expected 0 0 cafef00d 0",
                     stallm, bus_req, readdatam, err_pulse);
        end
        memtoregm = 1'b0;
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_wait_write();
        int nstall = 0;
        int nreq = 0;
        aluoutm = 32'h0000_0104;
        writedatam = 32'hDEAD_BEEF;
        for (int c = 0; c < 8; c++) begin
            bus_ack = (c == 4);
            memwritem = (c < 5);
            #1;
            if (stallm) nstall++;
            if (bus_req) nreq++;
            if (c == 1) begin
                total++;
                if (bus_we !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h0000_0104) begin
                    bad++;
                    $display("FAIL wr_bus: got we=%b wdata=%h addr=%h expected 1 deadbeef 00000104",
                             bus_we, bus_wdata, bus_addr);
                end
            end
            if (c == 5) begin
                total++;
                if (readdatam !== 32'd0 || stallm !== 1'b0) begin
                    bad++;
                    $display("FAIL wr_done: got rdata=%h stall=%b expected 00000000 0", readdatam, stallm);
                end
            end
            tick();
        end
        bus_ack = 1'b0;
        total++;
        if (nstall != 5 || nreq != 4) begin
            bad++;
            $display("FAIL wr_counts: got stall_cycles=%0d req_cycles=%0d expected 5 4", nstall, nreq);
        end
    endtask

    task automatic test_timeout();
        int nstall = 0;
        int nreq = 0;
        int nerr = 0;
        aluoutm = 32'h0000_0020;
        bus_ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            memtoregm = (c < 17);
            #1;
            if (stallm) nstall++;
            if (bus_req) nreq++;
            if (err_pulse) nerr++;
            if (c == 17) begin
                total++;
                if (err_pulse !== 1'b1 || err_count !== 8'd1 || readdatam !== 32'd0 || bus_req !== 1'b0) begin
                    bad++;
                    $display("FAIL to_done: got err=%b cnt=%0d rdata=%h req=%b expected 1 1 00000000 0",
                             err_pulse, err_count, readdatam, bus_req);
                end
            end
            if (c == 18) begin
                total++;
                if (stallm !== 1'b0 || err_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL to_resume: got stall=%b err=%b expected 0 0", stallm, err_pulse);
                end
            end
            tick();
        end
        total++;
        if (nstall != 17 || nreq != 16 || nerr != 1) begin
            bad++;
            $display("FAIL to_counts: got stall=%0d req=%0d errpulse=%0d expected 17 16 1", nstall, nreq, nerr);
        end
    endtask

    task automatic test_misaligned();
        aluoutm = 32'h0000_0013;
        memtoregm = 1'b1;
        #1;
        total++;
        if ({stallm, bus_req} !== 2'b10) begin
            bad++;
            $display("FAIL mis_idle: got stall/req=%b expected 10", {stallm, bus_req});
        end
        tick();
        total++;
        if (err_pulse !== 1'b1 || err_count !== 8'd2 || stallm !== 1'b0 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL mis_done: got err=%b cnt=%0d stall=%b req=%b expected 1 2 0 0",
                     err_pulse, err_count, stallm, bus_req);
        end
        memtoregm = 1'b0;
        tick();
        total++;
        if (err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL mis_pulse_len: got err=%b expected 0", err_pulse);
        end
    endtask

    task automatic test_reset_mid();
        aluoutm = 32'h0000_0040;
        memtoregm = 1'b1;
        tick();
        tick();
        total++;
        if (bus_req !== 1'b1 || stallm !== 1'b1) begin
            bad++;
            $display("FAIL rst_busy: got req=%b stall=%b expected 1 1", bus_req, stallm);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        memtoregm = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        #1;
        total++;
        if ({bus_req, bus_we, err_pulse, stallm} !== 4'b0000 ||
            {bus_addr, bus_wdata, readdatam, err_count} !== 104'd0) begin
            bad++;
            $display("FAIL rst_late_ack: got req=%b we=%b err=%b stall=%b addr=%h wdata=%h rdata=%h cnt=%0d expected all 0",
                     bus_req, bus_we, err_pulse, stallm, bus_addr, bus_wdata, readdatam, err_count);
        end
        tick();
    endtask

    task automatic test_saturation();
        aluoutm = 32'h0000_0101;
        for (int i = 0; i < 260; i++) begin
            memtoregm = 1'b1;
            tick();
            memtoregm = 1'b0;
            tick();
            if (i == 9) begin
                total++;
                if (err_count !== 8'd10) begin
                    bad++;
                    $display("FAIL sat_mid: got cnt=%0d expected 10", err_count);
                end
            end
        end
        total++;
        if (err_count !== 8'd255) begin
            bad++;
            $display("FAIL sat_cap: got cnt=%0d expected 255", err_count);
        end
        aluoutm = 32'h0000_0080;
        memtoregm = 1'b1;
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'h0BAD_CAFE;
        tick();
        total++;
        if (readdatam !== 32'h0BAD_CAFE || err_count !== 8'd255 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL sat_read: got rdata=%h cnt=%0d err=%b expected 0badcafe 255 0",
                     readdatam, err_count, err_pulse);
        end
        memtoregm = 1'b0;
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        aluoutm = 32'h0000_0200;
        writedatam = 32'h1111_2222;
        memwritem = 1'b1;
        memtoregm = 1'b1;
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'h9999_9999;
        #1;
        total++;
        if (bus_we !== 1'b1 || bus_addr !== 32'h0000_0200) begin
            bad++;
            $display("FAIL b2b_both_we: got we=%b addr=%h expected 1 00000200", bus_we, bus_addr);
        end
        tick();
        bus_ack = 1'b0;
        total++;
        if (readdatam !== 32'd0 || bus_req !== 1'b0 || stallm !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wr_done: got rdata=%h req=%b stall=%b expected 00000000 0 0",
                     readdatam, bus_req, stallm);
        end
        aluoutm = 32'h0000_0204;
        memwritem = 1'b0;
        memtoregm = 1'b1;
        tick();
        total++;
        if (stallm !== 1'b1 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got stall=%b req=%b expected 1 0", stallm, bus_req);
        end
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'h55AA_55AA;
        #1;
        total++;
        if (bus_addr !== 32'h0000_0204 || bus_we !== 1'b0 || bus_req !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rd_busy: got addr=%h we=%b req=%b expected 00000204 0 1", bus_addr, bus_we, bus_req);
        end
        tick();
        bus_ack = 1'b0;
        memtoregm = 1'b0;
        total++;
        if (readdatam !== 32'h55AA_55AA) begin
            bad++;
            $display("FAIL b2b_rd_data: got rdata=%h expected 55aa55aa", readdatam);
        end
        tick();
        tick();
        total++;
        if (stallm !== 1'b0 || bus_req !== 1'b0 || readdatam !== 32'h55AA_55AA) begin
            bad++;
            $display("FAIL b2b_nop_pass: got stall=%b req=%b rdata=%h expected 0 0 55aa55aa",
                     stallm, bus_req, readdatam);
        end
    endtask

    initial begin
        reset = 1'b1;
        aluoutm = '0;
        writedatam = '0;
        memwritem = 1'b0;
        memtoregm = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
